// File: rtl/hue_fade_pwm_if.sv
// Purpose: bundles the control inputs and LED/debug outputs of hue_fade_pwm.
// Latency: none, this is wiring only.
// Backpressure: none; enable/restart are levels/pulses, outputs are free-running.
// Ports: enable, restart (driven by master); pwm_out, level, seg, seg_wrap (driven by slave).
interface hue_fade_pwm_if #(
    parameter int NUM_CH       = 3,
    parameter int PWM_INTERVAL = 1200
);
    localparam int LVL_W = $clog2(PWM_INTERVAL + 1);
    localparam int SEG_W = $clog2(2 * NUM_CH);

    logic                      enable;
    logic                      restart;
    logic [NUM_CH-1:0]         pwm_out;
    logic [NUM_CH*LVL_W-1:0]   level;
    logic [SEG_W-1:0]          seg;
    logic                      seg_wrap;

    modport master (
        output enable, restart,
        input  pwm_out, level, seg, seg_wrap
    );

    modport slave (
        input  enable, restart,
        output pwm_out, level, seg, seg_wrap
    );
endinterface

// File: rtl/hue_fade_pwm.sv
// Purpose: multi-channel colour-wheel fader with per-channel PWM and period-aligned duty shadowing.
// Latency: level follows seg/step combinationally; a new level reaches pwm_out at the next PWM period start.
// Backpressure: none; enable=0 freezes the animation while PWM keeps running.
// Ports: clk, reset (sync, active-high); bus.enable, bus.restart in;
//        bus.pwm_out, bus.level, bus.seg, bus.seg_wrap out.
module hue_fade_pwm #(
    parameter int NUM_CH        = 3,
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEP_INTERVAL = 12000,
    parameter int STEPS         = 200
) (
    input  logic          clk,
    input  logic          reset,
    hue_fade_pwm_if.slave bus
);
    localparam int INC     = PWM_INTERVAL / STEPS;
    localparam int TOP     = INC * STEPS;
    localparam int NUM_SEG = 2 * NUM_CH;
    localparam int LVL_W   = $clog2(PWM_INTERVAL + 1);
    localparam int SEG_W   = $clog2(NUM_SEG);
    localparam int PRE_W   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int STEP_W  = $clog2(STEPS);
    localparam int CNT_W   = $clog2(PWM_INTERVAL);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_INTERVAL - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(NUM_SEG - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_INTERVAL - 1);
    localparam logic [LVL_W-1:0]  INC_L     = LVL_W'(INC);
    localparam logic [LVL_W-1:0]  TOP_L     = LVL_W'(TOP);
    localparam logic [SEG_W:0]    NSEG_X    = (SEG_W + 1)'(NUM_SEG);
    localparam logic [SEG_W-1:0]  NCH_S     = SEG_W'(NUM_CH);

    logic [PRE_W-1:0]        presc;
    logic [STEP_W-1:0]       step;
    logic [SEG_W-1:0]        seg;
    logic                    seg_wrap;
    logic [CNT_W-1:0]        pwm_cnt;
    logic [LVL_W-1:0]        shadow [NUM_CH];
    logic [NUM_CH*LVL_W-1:0] level;
    logic [NUM_CH-1:0]       pwm;
    logic                    tick;
    logic [LVL_W-1:0]        ramp;

    assign tick = bus.enable && (presc == PRE_LAST);
    // (STEPS-1)*INC < TOP <= PWM_INTERVAL, so neither ramp nor TOP-ramp can wrap.
    assign ramp = LVL_W'(step) * INC_L;

    // Animation position: prescaler -> step -> segment. Restart wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            step     <= '0;
            seg      <= '0;
            seg_wrap <= 1'b0;
        end else begin
            seg_wrap <= 1'b0;
            if (bus.restart) begin
                presc <= '0;
                step  <= '0;
                seg   <= '0;
            end else if (bus.enable) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (step == STEP_LAST) begin
                        step <= '0;
                        if (seg == SEG_LAST) begin
                            seg      <= '0;
                            seg_wrap <= 1'b1;
                        end else begin
                            seg <= seg + 1'b1;
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
            end
        end
    end

    // Free-running PWM period; duties are captured only on the last count so a
    // period never sees a mid-way duty change.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
        end else if (pwm_cnt == CNT_LAST) begin
            pwm_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) shadow[k] <= level[k*LVL_W +: LVL_W];
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Channel k runs 2k segments behind channel 0; offset stored mod NUM_SEG.
        localparam logic [SEG_W:0] OFS = (SEG_W + 1)'((NUM_SEG - 2 * k) % NUM_SEG);
        logic [SEG_W:0]   sum;
        logic [SEG_W-1:0] rel;
        logic [LVL_W-1:0] lvl;

        assign sum = {1'b0, seg} + OFS;
        assign rel = (sum >= NSEG_X) ? SEG_W'(sum - NSEG_X) : SEG_W'(sum);

        always_comb begin
            lvl = '0;
            if (rel == '0)         lvl = ramp;
            else if (rel < NCH_S)  lvl = TOP_L;
            else if (rel == NCH_S) lvl = TOP_L - ramp;
        end

        assign level[k*LVL_W +: LVL_W] = lvl;
        assign pwm[k] = LVL_W'(pwm_cnt) < shadow[k];
    end

    assign bus.level    = level;
    assign bus.pwm_out  = pwm;
    assign bus.seg      = seg;
    assign bus.seg_wrap = seg_wrap;
endmodule

// File: tb/tb_hue_fade_pwm.sv
module tb_hue_fade_pwm;
    localparam int NUM_CH        = 3;
    localparam int PWM_INTERVAL  = 8;
    localparam int STEP_INTERVAL = 4;
    localparam int STEPS         = 4;
    localparam int INC           = PWM_INTERVAL / STEPS;
    localparam int TOP           = INC * STEPS;
    localparam int NUM_SEG       = 2 * NUM_CH;
    localparam int LVL_W         = $clog2(PWM_INTERVAL + 1);
    localparam int SEG_W         = $clog2(NUM_SEG);
    localparam int SEG_CYC       = STEP_INTERVAL * STEPS;
    localparam int WHEEL         = SEG_CYC * NUM_SEG;

    logic clk = 1'b0;
    logic reset;

    hue_fade_pwm_if #(.NUM_CH(NUM_CH), .PWM_INTERVAL(PWM_INTERVAL)) bus ();

    hue_fade_pwm #(
        .NUM_CH(NUM_CH), .PWM_INTERVAL(PWM_INTERVAL),
        .STEP_INTERVAL(STEP_INTERVAL), .STEPS(STEPS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: t = enabled cycles since the animation origin (mod one wheel),
    // c = clock cycles since reset, shadow_m = duty of the running PWM period.
    int t = 0;
    int c = 0;
    bit wrap_m = 1'b0;
    int shadow_m [NUM_CH];

    // Channel k sees the wheel delayed by 2k segments: rise, hold high, fall, stay low.
    function automatic int ref_level(int k, int tt);
        int tk;
        tk = ((tt - k * 2 * SEG_CYC) % WHEEL + WHEEL) % WHEEL;
        if (tk < SEG_CYC)                return (tk / STEP_INTERVAL) * INC;
        if (tk < NUM_CH * SEG_CYC)       return TOP;
        if (tk < (NUM_CH + 1) * SEG_CYC) return TOP - ((tk - NUM_CH * SEG_CYC) / STEP_INTERVAL) * INC;
        return 0;
    endfunction

    function automatic logic [NUM_CH*LVL_W-1:0] exp_lvl();
        logic [NUM_CH*LVL_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*LVL_W +: LVL_W] = LVL_W'(ref_level(k, t));
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_pwm();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k] = ((c % PWM_INTERVAL) < shadow_m[k]);
        return v;
    endfunction

    function automatic logic [SEG_W-1:0] exp_seg();
        return SEG_W'(t / SEG_CYC);
    endfunction

    // Drive one clock with the given controls and advance the model; returns at the negedge.
    task automatic cycle(input bit en, input bit rs, input bit rst);
        int old_t;
        int old_c;
        bus.enable  = en;
        bus.restart = rs;
        reset       = rst;
        @(posedge clk);
        old_t  = t;
        old_c  = c;
        wrap_m = 1'b0;
        if (rst) begin
            t = 0;
            c = 0;
            for (int k = 0; k < NUM_CH; k++) shadow_m[k] = 0;
        end else begin
            if (old_c % PWM_INTERVAL == PWM_INTERVAL - 1)
                for (int k = 0; k < NUM_CH; k++) shadow_m[k] = ref_level(k, old_t);
            c = old_c + 1;
            if (rs) t = 0;
            else if (en) begin
                t      = (old_t + 1) % WHEEL;
                wrap_m = (old_t == WHEEL - 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic advance_to(input int target);
        repeat ((target - t + WHEEL) % WHEEL) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle($urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        checks++; if (bus.seg !== 3'd0) begin errors++; $display("FAIL reset_seg got %0d want 0", bus.seg); end
        checks++; if (bus.level !== 12'h800) begin errors++; $display("FAIL reset_level got %h want 800", bus.level); end
        checks++; if (bus.pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm got %b want 000", bus.pwm_out); end
        checks++; if (bus.seg_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.seg_wrap); end
    endtask

    task automatic test_pwm_shadow();
        cycle(1'b1, 1'b0, 1'b1);
        checks++; if (bus.pwm_out !== 3'b000) begin errors++; $display("FAIL shadow_c0 got %b want 000", bus.pwm_out); end
        for (int i = 1; i < 24; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            // level0 is 2 at the first load, 6 at the second; ch2 sits at TOP.
            checks++;
            if (bus.pwm_out[0] !== ((i < 8) ? 1'b0 : (i < 16) ? ((i % 8) < 2) : ((i % 8) < 6))) begin
                errors++; $display("FAIL shadow_ch0 cyc=%0d got %b", i, bus.pwm_out[0]);
            end
            checks++;
            if (bus.pwm_out[2] !== (i >= 8)) begin
                errors++; $display("FAIL shadow_ch2 cyc=%0d got %b want %b", i, bus.pwm_out[2], i >= 8);
            end
        end
    endtask

    task automatic test_ramp_wrap();
        int wraps;
        wraps = 0;
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= WHEEL + 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (bus.seg_wrap === 1'b1) wraps++;
            checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL ramp_seg cyc=%0d got %0d want %0d", i, bus.seg, exp_seg()); end
            checks++; if (bus.level !== exp_lvl()) begin errors++; $display("FAIL ramp_level cyc=%0d got %h want %h", i, bus.level, exp_lvl()); end
            checks++; if (bus.pwm_out !== exp_pwm()) begin errors++; $display("FAIL ramp_pwm cyc=%0d got %b want %b", i, bus.pwm_out, exp_pwm()); end
            checks++; if (bus.seg_wrap !== wrap_m) begin errors++; $display("FAIL ramp_wrap cyc=%0d got %b want %b", i, bus.seg_wrap, wrap_m); end
            if (i == WHEEL) begin
                checks++; if (bus.level !== 12'h800) begin errors++; $display("FAIL wrap_level got %h want 800", bus.level); end
            end
        end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL wrap_count got %0d want 1", wraps); end
    endtask

    task automatic test_freeze();
        logic [NUM_CH*LVL_W-1:0] frozen;
        logic [NUM_CH-1:0]       prev;
        int                      toggles;
        cycle(1'b1, 1'b0, 1'b1);
        advance_to(SEG_CYC + 2 * STEP_INTERVAL);
        frozen  = exp_lvl();
        prev    = bus.pwm_out;
        toggles = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (bus.pwm_out !== prev) toggles++;
            prev = bus.pwm_out;
            checks++; if (bus.seg !== 3'd1) begin errors++; $display("FAIL freeze_seg got %0d want 1", bus.seg); end
            checks++; if (bus.level !== frozen) begin errors++; $display("FAIL freeze_level got %h want %h", bus.level, frozen); end
            checks++; if (bus.pwm_out !== exp_pwm()) begin errors++; $display("FAIL freeze_pwm got %b want %b", bus.pwm_out, exp_pwm()); end
        end
        checks++; if (toggles == 0) begin errors++; $display("FAIL freeze_toggle got 0 toggles want >0"); end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL resume_seg got %0d want %0d", bus.seg, exp_seg()); end
            checks++; if (bus.level !== exp_lvl()) begin errors++; $display("FAIL resume_level got %h want %h", bus.level, exp_lvl()); end
        end
    endtask

    task automatic test_restart_reset();
        cycle(1'b1, 1'b0, 1'b1);
        advance_to(3 * SEG_CYC + 3 * STEP_INTERVAL + STEP_INTERVAL - 1);
        cycle(1'b1, 1'b1, 1'b0);
        checks++; if (bus.seg !== 3'd0) begin errors++; $display("FAIL restart_seg got %0d want 0", bus.seg); end
        checks++; if (bus.level !== 12'h800) begin errors++; $display("FAIL restart_level got %h want 800", bus.level); end
        checks++; if (bus.seg_wrap !== 1'b0) begin errors++; $display("FAIL restart_wrap got %b want 0", bus.seg_wrap); end
        repeat (3) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++; if (bus.level[LVL_W-1:0] !== 4'd0) begin errors++; $display("FAIL restart_hold got %0d want 0", bus.level[LVL_W-1:0]); end
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (bus.level[LVL_W-1:0] !== 4'd2) begin errors++; $display("FAIL restart_step got %0d want 2", bus.level[LVL_W-1:0]); end
        advance_to(2 * SEG_CYC + 5);
        cycle(1'b1, 1'b0, 1'b1);
        checks++; if (bus.pwm_out !== 3'b000) begin errors++; $display("FAIL midreset_pwm got %b want 000", bus.pwm_out); end
        checks++; if (bus.seg !== 3'd0) begin errors++; $display("FAIL midreset_seg got %0d want 0", bus.seg); end
        checks++; if (bus.level !== 12'h800) begin errors++; $display("FAIL midreset_level got %h want 800", bus.level); end
    endtask

    task automatic test_random();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 400) == 0);
            checks++; if (bus.seg !== exp_seg()) begin errors++; $display("FAIL rand_seg i=%0d got %0d want %0d", i, bus.seg, exp_seg()); end
            checks++; if (bus.level !== exp_lvl()) begin errors++; $display("FAIL rand_level i=%0d got %h want %h", i, bus.level, exp_lvl()); end
            checks++; if (bus.pwm_out !== exp_pwm()) begin errors++; $display("FAIL rand_pwm i=%0d got %b want %b", i, bus.pwm_out, exp_pwm()); end
            checks++; if (bus.seg_wrap !== wrap_m) begin errors++; $display("FAIL rand_wrap i=%0d got %b want %b", i, bus.seg_wrap, wrap_m); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.restart = 1'b0;
        for (int k = 0; k < NUM_CH; k++) shadow_m[k] = 0;
        test_reset();
        test_pwm_shadow();
        test_ramp_wrap();
        test_freeze();
        test_restart_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
